// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges MEM/WB results with long-latency results held in a one-entry buffer.
// Also keeps a busy scoreboard for decode. WB_STARVE_EN adds the starvation counter and stall_req.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_waddr,
    input  logic [31:0] ll_wdata,
    input  logic        iss_valid,
    input  logic [4:0]  iss_waddr,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        chk_busy1,
    output logic        chk_busy2,
    output logic        stall_req,
    output logic        sb_err,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    logic        buf_valid_q, buf_valid_d;
    logic [4:0]  buf_addr_q, buf_addr_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] busy_q, busy_d;
    logic        sb_err_q, sb_err_d;
    logic        stall_q;
    logic        pipe_req, grant_pipe, grant_buf, capture;

    assign pipe_req = pipe_we && (pipe_waddr != 5'd0);
    assign ll_ready = !buf_valid_q && !rst;
    assign capture  = ll_valid && ll_ready;

`ifdef WB_STARVE_EN
    logic [3:0] cnt_q, cnt_d;
    logic       stall_d;

    // A starved buffer outranks the pipeline; the stalled pipeline re-presents its request.
    assign grant_buf  = buf_valid_q && (stall_q || !pipe_req);
    assign grant_pipe = pipe_req && !stall_q;

    always_comb begin
        cnt_d = 4'd0;
        if (buf_valid_q && !grant_buf)
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        stall_d = (cnt_d >= 4'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end
`else
    assign grant_buf  = buf_valid_q && !pipe_req;
    assign grant_pipe = pipe_req;
    // Constant 0 for any legal STARVE_LIMIT.
    assign stall_q    = (STARVE_LIMIT == 0);
`endif

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        sb_err_d    = sb_err_q;

        if (capture) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = ll_waddr;
            buf_data_d  = ll_wdata;
        end

        if (grant_pipe) begin
            we_d    = 1'b1;
            waddr_d = pipe_waddr;
            wdata_d = pipe_wdata;
        end else if (grant_buf) begin
            // An address-0 entry is drained without writing.
            we_d        = (buf_addr_q != 5'd0);
            waddr_d     = buf_addr_q;
            wdata_d     = buf_data_q;
            buf_valid_d = 1'b0;
            busy_d[buf_addr_q] = 1'b0;
        end

        // Set after clear so a same-cycle issue wins; a bit being drained is not a conflict.
        if (iss_valid && (iss_waddr != 5'd0)) begin
            if (busy_q[iss_waddr] && !(grant_buf && (buf_addr_q == iss_waddr)))
                sb_err_d = 1'b1;
            busy_d[iss_waddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 5'd0;
            buf_data_q  <= 32'd0;
            we_q        <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'd0;
            busy_q      <= 32'd0;
            sb_err_q    <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign chk_busy1 = busy_q[chk_addr1];
    assign chk_busy2 = busy_q[chk_addr2];
    assign stall_req = stall_q;
    assign sb_err    = sb_err_q;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: pipeline vector table plus hand sequences for
// scoreboard, contention/starvation and set/clear collision.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic [4:0]  chk_addr1, chk_addr2;
    logic        chk_busy1, chk_busy2;
    logic        stall_req, sb_err, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
        .iss_valid(iss_valid), .iss_waddr(iss_waddr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .stall_req(stall_req), .sb_err(sb_err),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    typedef struct {
        logic        p_we;
        logic [4:0]  p_addr;
        logic [31:0] p_data;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        ll_valid = 0; ll_waddr = 0; ll_wdata = 0;
        iss_valid = 0; iss_waddr = 0;
    endtask

    initial begin
        idle();
        chk_addr1 = 0; chk_addr2 = 0;

        // Reset with a long-latency producer already asserting valid.
        rst = 1; ll_valid = 1; ll_waddr = 5'd7; ll_wdata = 32'h77;
        step(); step();
        chk("rst_ll_ready", ll_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy1", chk_busy1, 0);
        chk("rst_busy2", chk_busy2, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_sb_err", sb_err, 0);
        ll_valid = 0;
        rst = 0;
        step();
        chk("post_rst_ll_ready", ll_ready, 1);

        // Pipeline-only vectors: result appears one cycle after the request.
        vecs[0] = '{1, 5'd5,  32'h1234,     1, 5'd5,  32'h1234};
        vecs[1] = '{1, 5'd0,  32'hFFFF,     0, 5'd0,  32'h0};
        vecs[2] = '{1, 5'd31, 32'hCAFEF00D, 1, 5'd31, 32'hCAFEF00D};
        vecs[3] = '{0, 5'd12, 32'h5555,     0, 5'd0,  32'h0};
        vecs[4] = '{1, 5'd1,  32'h0,        1, 5'd1,  32'h0};
        vecs[5] = '{1, 5'd17, 32'h80000001, 1, 5'd17, 32'h80000001};
        for (int i = 0; i < 6; i++) begin
            pipe_we = vecs[i].p_we; pipe_waddr = vecs[i].p_addr; pipe_wdata = vecs[i].p_data;
            step();
            chk($sformatf("vec%0d_we", i), we, vecs[i].e_we);
            if (vecs[i].e_we) begin
                chk($sformatf("vec%0d_waddr", i), waddr, vecs[i].e_addr);
                chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].e_data);
            end
        end
        idle();
        step();

        // Scoreboard: issue r8, later its long-latency result drains through the buffer.
        chk_addr1 = 5'd8;
        iss_valid = 1; iss_waddr = 5'd8;
        step();
        iss_valid = 0;
        chk("sb_busy_set", chk_busy1, 1);
        step(); step();
        chk("sb_busy_held", chk_busy1, 1);
        chk("sb_ll_ready", ll_ready, 1);
        ll_valid = 1; ll_waddr = 5'd8; ll_wdata = 32'hDEAD;
        step();
        ll_valid = 0;
        chk("sb_buf_full", ll_ready, 0);
        chk("sb_no_we_yet", we, 0);
        step();
        chk("sb_we", we, 1);
        chk("sb_waddr", waddr, 8);
        chk("sb_wdata", wdata, 32'hDEAD);
        chk("sb_busy_clr", chk_busy1, 0);
        chk("sb_ll_ready_again", ll_ready, 1);
        step();
        chk("sb_we_drop", we, 0);

        // Address 0: never scoreboarded, buffered entry dropped with we=0.
        chk_addr2 = 5'd0;
        iss_valid = 1; iss_waddr = 5'd0;
        ll_valid = 1; ll_waddr = 5'd0; ll_wdata = 32'hBAD;
        step();
        idle();
        chk("zero_busy", chk_busy2, 0);
        step();
        chk("zero_drop_we", we, 0);
        chk("zero_buf_empty", ll_ready, 1);
        chk("zero_sb_err", sb_err, 0);

        // Contention: r9 buffered while the pipeline writes every cycle.
        ll_valid = 1; ll_waddr = 5'd9; ll_wdata = 32'hAA;
        step();
        ll_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont%0d_stall", i), stall_req, 0);
            pipe_we = 1; pipe_waddr = 5'(10 + i); pipe_wdata = 32'(100 + i);
            step();
            chk($sformatf("cont%0d_waddr", i), waddr, 10 + i);
            chk($sformatf("cont%0d_ll_ready", i), ll_ready, 0);
        end
        pipe_waddr = 5'd14; pipe_wdata = 32'd114;
`ifdef WB_STARVE_EN
        chk("cont_stall_hi", stall_req, 1);
        step();
        chk("cont_buf_waddr", waddr, 9);
        chk("cont_buf_wdata", wdata, 32'hAA);
        chk("cont_buf_we", we, 1);
        chk("cont_stall_lo", stall_req, 0);
        step();
        chk("cont_pipe_resume", waddr, 14);
        chk("cont_pipe_wdata", wdata, 32'd114);
`else
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("cont_nostall%0d", i), stall_req, 0);
            pipe_waddr = 5'(14 + i); pipe_wdata = 32'(114 + i);
            step();
            chk($sformatf("cont_pipe%0d_waddr", i), waddr, 14 + i);
        end
        pipe_we = 0;
        step();
        chk("cont_buf_waddr", waddr, 9);
        chk("cont_buf_wdata", wdata, 32'hAA);
        chk("cont_buf_we", we, 1);
`endif
        idle();
        step();

        // Set/clear collision on r3, then a true double issue.
        chk_addr1 = 5'd3; chk_addr2 = 5'd3;
        iss_valid = 1; iss_waddr = 5'd3;
        step();
        iss_valid = 0;
        ll_valid = 1; ll_waddr = 5'd3; ll_wdata = 32'h33;
        step();
        ll_valid = 0;
        iss_valid = 1; iss_waddr = 5'd3;
        step();
        iss_valid = 0;
        chk("coll_we", we, 1);
        chk("coll_waddr", waddr, 3);
        chk("coll_busy1", chk_busy1, 1);
        chk("coll_busy2", chk_busy2, 1);
        chk("coll_sb_err", sb_err, 0);
        // A pipeline write to a busy register leaves the bit set.
        pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'h3;
        step();
        pipe_we = 0;
        chk("pipe_busy_kept", chk_busy1, 1);
        iss_valid = 1; iss_waddr = 5'd3;
        step();
        iss_valid = 0;
        chk("dbl_sb_err", sb_err, 1);
        chk("dbl_busy", chk_busy1, 1);
        step(); step();
        chk("sticky_sb_err", sb_err, 1);

        // Reset mid-operation: buffer and scoreboard discarded.
        ll_valid = 1; ll_waddr = 5'd4; ll_wdata = 32'h44;
        step();
        ll_valid = 0;
        rst = 1;
        step();
        rst = 0;
        chk("rst2_sb_err", sb_err, 0);
        chk("rst2_busy", chk_busy1, 0);
        chk("rst2_we", we, 0);
        step();
        chk("rst2_no_drain", we, 0);
        chk("rst2_ll_ready", ll_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
